// File: rtl/mad_search_ctrl.sv
// rtl/mad_search_ctrl.sv - full-search SAD scheduler: raster candidate reads, tag pipeline, running minimum.
// Optional feature: define MAD_CTRL_EARLY_EXIT_EN to stop feeding once a zero SAD has been compared.
module mad_search_ctrl #(
  parameter int X_W      = 4,
  parameter int Y_W      = 4,
  parameter int ROW_W    = 2,
  parameter int PIPE_LAT = 6,
  parameter int SAD_W    = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     cand_rd_en,
  output logic [Y_W+X_W+ROW_W-1:0] cand_rd_addr,
  input  logic [SAD_W-1:0]         sad_in,
  output logic [SAD_W-1:0]         best_sad,
  output logic [X_W-1:0]           best_x,
  output logic [Y_W-1:0]           best_y,
  output logic                     best_valid
);

  localparam int AW = Y_W + X_W + ROW_W;
  localparam int DW = $clog2(PIPE_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_FEED, S_DRAIN, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  drain_q, drain_d;

  logic           tag_v_q [PIPE_LAT];
  logic [X_W-1:0] tag_x_q [PIPE_LAT];
  logic [Y_W-1:0] tag_y_q [PIPE_LAT];

  logic [SAD_W-1:0] best_sad_q;
  logic [X_W-1:0]   best_x_q;
  logic [Y_W-1:0]   best_y_q;
  logic             best_valid_q;

  logic [ROW_W-1:0] cur_row;
  logic [X_W-1:0]   cur_x;
  logic [Y_W-1:0]   cur_y;
  logic             push_v;
  logic             tag_exit;
  logic             sad_win;
  logic             early_stop;

  assign cur_row  = addr_q[ROW_W-1:0];
  assign cur_x    = addr_q[ROW_W +: X_W];
  assign cur_y    = addr_q[ROW_W+X_W +: Y_W];
  assign push_v   = (state_q == S_FEED) && (cur_row == '1);
  assign tag_exit = tag_v_q[PIPE_LAT-1];
  // Strict less-than: a later candidate with an equal SAD never displaces the earlier one.
  assign sad_win  = !best_valid_q || (sad_in < best_sad_q);

`ifdef MAD_CTRL_EARLY_EXIT_EN
  assign early_stop = tag_exit && (sad_in == '0);
`else
  assign early_stop = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = '0;
          state_d = S_FEED;
        end
      end
      S_FEED: begin
        addr_d  = addr_q + AW'(1);
        drain_d = '0;
        if (addr_q == '1 || early_stop) state_d = S_DRAIN;
      end
      // Wait until every read issued during FEED has flushed out of the tag pipe.
      S_DRAIN: begin
        if (drain_q == DW'(PIPE_LAT - 1)) state_d = S_DONE;
        else                              drain_d = drain_q + DW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      drain_q <= drain_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) begin
        tag_v_q[i] <= 1'b0;
        tag_x_q[i] <= '0;
        tag_y_q[i] <= '0;
      end
    end else begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        tag_v_q[i] <= tag_v_q[i-1];
        tag_x_q[i] <= tag_x_q[i-1];
        tag_y_q[i] <= tag_y_q[i-1];
      end
      tag_v_q[0] <= push_v;
      tag_x_q[0] <= cur_x;
      tag_y_q[0] <= cur_y;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      best_sad_q   <= '1;
      best_x_q     <= '0;
      best_y_q     <= '0;
      best_valid_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      best_valid_q <= 1'b0;
    end else if (tag_exit) begin
      if (sad_win) begin
        best_sad_q <= sad_in;
        best_x_q   <= tag_x_q[PIPE_LAT-1];
        best_y_q   <= tag_y_q[PIPE_LAT-1];
      end
      best_valid_q <= 1'b1;
    end
  end

  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign cand_rd_en   = (state_q == S_FEED);
  assign cand_rd_addr = addr_q;
  assign best_sad     = best_sad_q;
  assign best_x       = best_x_q;
  assign best_y       = best_y_q;
  assign best_valid   = best_valid_q;

endmodule
